// File: rtl/bcd_serial_adder_pkg.sv
// Shared constants for the digit-serial BCD adder: digit width, BCD limits
// and the width used for the adder's state enumeration.
package bcd_serial_adder_pkg;

  localparam int DIGIT_W = 4;
  localparam int STATE_W = 2;

  localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_digit_add.sv
// One BCD digit adder: a + b + C_in with decimal correction.
// Purely combinational; the serial adder time-shares a single copy.
module bcd_digit_add
  import bcd_serial_adder_pkg::*;
(
  input  logic               C_in,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic [DIGIT_W-1:0] sum,
  output logic               C_out
);

  logic [DIGIT_W:0] t;
  logic [DIGIT_W:0] t_corr;

  // Binary sum plus the +6 correction used when the result leaves 0..9.
  // Out-of-range nibbles follow the same rule; the result wraps mod 16.
  always_comb begin
    t      = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, C_in};
    t_corr = t + {1'b0, BCD_CORR};
    if (t > {1'b0, BCD_MAX}) begin
      sum   = t_corr[DIGIT_W-1:0];
      C_out = 1'b1;
    end else begin
      sum   = t[DIGIT_W-1:0];
      C_out = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder. Operands are captured on an accepted start,
// then one digit pair is added per cycle (least significant first) through a
// shared bcd_digit_add. The result is flagged with a one-cycle done pulse and
// held until the next accepted start.
//
// Handshake: start is a request sampled only while idle; a start seen while
// busy or finishing is dropped, never queued. done pulses for exactly one
// cycle, and sum/C_out/err are valid from that cycle until the next capture.
module bcd_serial_adder
  import bcd_serial_adder_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    C_in,
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic [DIGIT_W*DIGITS-1:0] sum,
  output logic                    C_out,
  output logic                    err
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                      state;
  logic [IDX_W-1:0]            idx;
  logic                        carry_q;
  logic [DIGIT_W*DIGITS-1:0]   a_q;
  logic [DIGIT_W*DIGITS-1:0]   b_q;

  logic [DIGIT_W-1:0]          a_d;
  logic [DIGIT_W-1:0]          b_d;
  logic [DIGIT_W-1:0]          d_sum;
  logic                        d_cout;
  logic                        nibble_bad;

  // Select the digit pair addressed by the index from the captured operands.
  always_comb begin
    a_d = '0;
    b_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        a_d = a_q[i*DIGIT_W +: DIGIT_W];
        b_d = b_q[i*DIGIT_W +: DIGIT_W];
      end
    end
    nibble_bad = (a_d > BCD_MAX) || (b_d > BCD_MAX);
  end

  bcd_digit_add u_digit (
    .C_in  (carry_q),
    .a     (a_d),
    .b     (b_d),
    .sum   (d_sum),
    .C_out (d_cout)
  );

  // Control FSM with index counter, operand/carry capture and result demux.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      C_out   <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= C_in;
            idx     <= '0;
            sum     <= '0;
            err     <= 1'b0;
            C_out   <= 1'b0;
            busy    <= 1'b1;
            state   <= ADD;
          end
        end
        ADD: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
              sum[i*DIGIT_W +: DIGIT_W] <= d_sum;
            end
          end
          carry_q <= d_cout;
          if (nibble_bad) begin
            err <= 1'b1;
          end
          if (idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // Final carry is published together with the done pulse.
          C_out <= carry_q;
          done  <= 1'b1;
          busy  <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
